button_db_multi: RTL and testbench
==================================

BUTTON_DB_MULTI -- requirements
Module: button_db_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter TICK_DIV, default 1000000: clk_100MHz cycles per debounce tick (10 ms), >=2.
REQ-003 Parameter STABLE_TICKS, default 2: consecutive ticks of a new raw value required before it is accepted, 1..255.
REQ-004 Parameter REPEAT_DELAY, default 50: ticks a level must be held before the first auto-repeat pulse, >=1.
REQ-005 Parameter REPEAT_RATE, default 10: ticks between subsequent auto-repeat pulses, >=1.
REQ-006 clk_100MHz  input  1  system clock; the only clock in the block.
REQ-007 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 k  input  N_CH  raw, asynchronous, bouncing button inputs; bit i is channel i.
REQ-009 level  output  N_CH  debounced button state per channel.
REQ-010 press  output  N_CH  one-cycle pulse per channel on an accepted 0->1 transition, or on an auto-repeat.
REQ-011 release  output  N_CH  one-cycle pulse per channel on an accepted 1->0 transition.
REQ-012 tick  output  1  one-cycle debounce-tick strobe, shared by all channels.

Function
REQ-013 Each k bit SHALL pass through a 2-flop synchroniser clocked by clk_100MHz before any other logic uses it.
REQ-014 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-015 Per channel: when the synchronised input differs from level at a tick, the stability count SHALL increment; when they are equal at any cycle, the count SHALL clear to 0.
REQ-016 When the stability count reaches STABLE_TICKS, level SHALL toggle on that tick cycle and the count SHALL clear in the same cycle.
REQ-017 press[i] SHALL be high for exactly the one cycle in which level[i] changes 0->1; release[i] SHALL be high for exactly the one cycle in which level[i] changes 1->0.
REQ-018 A raw glitch shorter than STABLE_TICKS ticks SHALL produce no level change and no pulse.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous, independent pulses.
REQ-020 press and release SHALL never be high in the same cycle on the same channel.
REQ-021 Worst-case acceptance latency from a stable raw edge SHALL be 2 + STABLE_TICKS*TICK_DIV cycles.

Reset
REQ-022 While rst_n is low: level, press, release, tick, all counters and synchroniser flops SHALL be 0.
REQ-023 After rst_n deasserts, a button already held SHALL be accepted through the normal STABLE_TICKS path and SHALL produce a press pulse.
REQ-024 A reset asserted mid-debounce or mid-repeat SHALL discard all in-progress counts, and SHALL emit no pulse on entry to or exit from reset.

Configuration
REQ-025 Macro BUTTON_DB_AUTOREPEAT_EN enables auto-repeat; when it is undefined, no repeat counter exists and press fires only per REQ-017.
REQ-026 With BUTTON_DB_AUTOREPEAT_EN defined, the per-channel FSM SHALL have states IDLE (level=0), HOLD and REPEAT.
REQ-027 The FSM SHALL go IDLE->HOLD on acceptance of 0->1, clearing the repeat count.
REQ-028 The FSM SHALL go HOLD->REPEAT after REPEAT_DELAY ticks and pulse press in that cycle.
REQ-029 In REPEAT, the FSM SHALL pulse press every REPEAT_RATE ticks.
REQ-030 From HOLD or REPEAT, the FSM SHALL return to IDLE on acceptance of 1->0; no further repeat pulses SHALL be emitted once level=0.

Structure
REQ-031 Package button_db_pkg SHALL hold the repeat FSM state enum and the counter-width function clog2-based width definitions.
REQ-032 The per-channel logic (synchroniser, stability counter, edge pulses, repeat FSM) SHALL be sub-module button_db_channel, instantiated N_CH times.
REQ-033 The tick generator SHALL be a single instance in the top level.

Verification (TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_CH=4)
REQ-034 Hold k[0]=1 steady -> level[0] rises within 2+12 cycles; press[0] high exactly 1 cycle; release stays 0.
REQ-035 Toggle k[1] high for 2 ticks then low -> level[1], press[1] and release[1] all remain 0.
REQ-036 Raise k[2] and k[3] in the same cycle, later drop k[3] only -> both press pulses are coincident; only release[3] fires.
REQ-037 With BUTTON_DB_AUTOREPEAT_EN, hold k[0] for 20 ticks after acceptance -> press[0] at acceptance, then +5 ticks, then every 2 ticks; all stop after release[0].
REQ-038 Assert rst_n=0 mid-count while k[0]=1, then deassert -> all outputs 0 during reset; press[0] fires once 3 ticks after deassertion.

Source files
------------

// File: rtl/button_db_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
// The repeat FSM states are only used when BUTTON_DB_AUTOREPEAT_EN is defined.
package button_db_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_db_channel.sv
// One debounced button: 2-flop synchroniser, tick-based stability counter, edge pulses.
// Auto-repeat FSM is built only when BUTTON_DB_AUTOREPEAT_EN is defined.
module button_db_channel
    import button_db_pkg::*;
#(
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic tick,
    input  logic k,
    output logic level,
    output logic press,
    output logic release_o
);

    localparam int STAB_W = cnt_width(STABLE_TICKS);

    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d, stab_inc;
    logic              rise, fall;

    always_comb begin
        stab_inc   = stab_cnt_q + 1'b1;
        stab_cnt_d = stab_cnt_q;
        level_d    = level_q;
        if (sync2_q == level_q) begin
            stab_cnt_d = '0;
        end else if (tick) begin
            if (stab_inc == STAB_W'(STABLE_TICKS)) begin
                level_d    = ~level_q;
                stab_cnt_d = '0;
            end else begin
                stab_cnt_d = stab_inc;
            end
        end
        rise      = level_d & ~level_q;
        fall      = ~level_d & level_q;
        release_d = fall;
    end

`ifdef BUTTON_DB_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
    logic             rpt_fire;

    // A release accepted on a tick wins over any repeat due on that same tick.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        rpt_inc   = rpt_cnt_q + 1'b1;
        case (state_q)
            RPT_IDLE: begin
                if (rise) begin
                    state_d   = RPT_HOLD;
                    rpt_cnt_d = '0;
                end
            end
            RPT_HOLD: begin
                if (fall) begin
                    state_d   = RPT_IDLE;
                    rpt_cnt_d = '0;
                end else if (tick) begin
                    if (rpt_inc == RPT_W'(REPEAT_DELAY)) begin
                        state_d   = RPT_REPEAT;
                        rpt_cnt_d = '0;
                        rpt_fire  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
                end
            end
            RPT_REPEAT: begin
                if (fall) begin
                    state_d   = RPT_IDLE;
                    rpt_cnt_d = '0;
                end else if (tick) begin
                    if (rpt_inc == RPT_W'(REPEAT_RATE)) begin
                        rpt_cnt_d = '0;
                        rpt_fire  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
                end
            end
            default: begin
                state_d   = RPT_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RPT_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign press_d = rise | rpt_fire;
`else
    assign press_d = rise;
`endif

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            stab_cnt_q <= '0;
        end else begin
            sync1_q    <= k;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Pulses are registered alongside level so they coincide with its first changed cycle.
    assign level     = level_q;
    assign press     = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_db_multi.sv
// N_CH independent button debouncers sharing one debounce-tick generator.
// Define BUTTON_DB_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_db_multi
    import button_db_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 1000000,
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic            clk_100MHz,
    input  logic            rst_n,
    input  logic [N_CH-1:0] k,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    // "release" is a reserved word in SystemVerilog, hence the suffix.
    output logic [N_CH-1:0] release_o,
    output logic            tick
);

    localparam int TICK_W = cnt_width(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        button_db_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .rst_n      (rst_n),
            .tick       (tick),
            .k          (k[gi]),
            .level      (level[gi]),
            .press      (press[gi]),
            .release_o  (release_o[gi])
        );
    end

endmodule

// File: tb/tb_button_db_multi.sv
// Directed bench for button_db_multi with TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.
// Repeat-timing expectations follow BUTTON_DB_AUTOREPEAT_EN.
module tb_button_db_multi;

    localparam int N_CH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] k;
    logic [N_CH-1:0] level, press, release_o;
    logic            tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int press_cnt [N_CH];
    int rel_cnt   [N_CH];
    int overlap_cnt = 0;
    int p0_times [$];

    button_db_multi #(
        .N_CH         (N_CH),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .k          (k),
        .level      (level),
        .press      (press),
        .release_o  (release_o),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (press[i] === 1'b1) press_cnt[i]++;
            if (release_o[i] === 1'b1) rel_cnt[i]++;
            if (press[i] === 1'b1 && release_o[i] === 1'b1) overlap_cnt++;
        end
        if (press[0] === 1'b1) p0_times.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n cycles; sample just after the falling edge, once the monitor has updated.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int t, t0, t_acc, t_rel, n_after, snap_p0, snap_rel;

    initial begin
        rst_n = 1'b0;
        k     = '0;
        step(3);
        check("rst_level", 32'(level), 0);
        check("rst_press", 32'(press), 0);
        check("rst_release", 32'(release_o), 0);
        check("rst_tick", 32'(tick), 0);
        rst_n = 1'b1;

        // Tick strobe: one cycle wide, period TICK_DIV
        t = 0;
        while (!tick && t < 10) begin step(1); t++; end
        check("tick_seen", 32'(tick), 1);
        t0 = cyc;
        step(1);
        check("tick_width", 32'(tick), 0);
        t = 0;
        while (!tick && t < 10) begin step(1); t++; end
        check("tick_period", 32'(cyc - t0), 4);

        // Channel 0 steady press, accepted within 2 + 3*4 cycles
        p0_times.delete();
        k[0] = 1'b1;
        t = 0;
        while (!level[0] && t < 20) begin step(1); t++; end
        check("ch0_accept_within_14", 32'(t <= 14), 1);
        check("ch0_press_at_rise", 32'(press[0]), 1);
        t_acc = cyc;
        step(1);
        check("ch0_press_width", 32'(press[0]), 0);
        check("ch0_no_release", 32'(rel_cnt[0]), 0);

        // Hold 20 ticks past acceptance
        step(79);
        check("ch0_first_press_time", 32'((p0_times.size() > 0) ? p0_times[0] - t_acc : -1), 0);
`ifdef BUTTON_DB_AUTOREPEAT_EN
        check("ch0_repeat_count", 32'(p0_times.size()), 9);
        for (int i = 1; i < p0_times.size() && i < 9; i++)
            check($sformatf("ch0_repeat_gap%0d", i), 32'(p0_times[i] - p0_times[i-1]), (i == 1) ? 20 : 8);
`else
        check("ch0_no_repeat", 32'(p0_times.size()), 1);
`endif
        k[0] = 1'b0;
        t = 0;
        while (!release_o[0] && t < 20) begin step(1); t++; end
        check("ch0_release_seen", 32'(release_o[0]), 1);
        t_rel = cyc;
        step(30);
        n_after = 0;
        foreach (p0_times[i]) if (p0_times[i] >= t_rel) n_after++;
        check("ch0_no_press_after_release", 32'(n_after), 0);
        check("ch0_release_count", 32'(rel_cnt[0]), 1);

        // Channel 1 glitch of two ticks
        k[1] = 1'b1;
        step(8);
        k[1] = 1'b0;
        step(30);
        check("ch1_glitch_level", 32'(level[1]), 0);
        check("ch1_glitch_press", 32'(press_cnt[1]), 0);
        check("ch1_glitch_release", 32'(rel_cnt[1]), 0);

        // Channels 2 and 3 together, then drop 3 only
        k[3:2] = 2'b11;
        t = 0;
        while (!press[2] && !press[3] && t < 20) begin step(1); t++; end
        check("ch23_press_coincident", 32'(press[3:2]), 3);
        step(10);
        k[3] = 1'b0;
        step(25);
        check("ch3_release_count", 32'(rel_cnt[3]), 1);
        check("ch2_release_count", 32'(rel_cnt[2]), 0);
        check("ch23_levels", 32'(level[3:2]), 1);

        // Reset mid-debounce on channel 0
        k[0] = 1'b1;
        step(6);
        snap_p0  = press_cnt[0];
        snap_rel = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
        rst_n = 1'b0;
        step(1);
        check("midrst_level", 32'(level), 0);
        check("midrst_press", 32'(press), 0);
        check("midrst_release", 32'(release_o), 0);
        check("midrst_tick", 32'(tick), 0);
        step(3);
        rst_n = 1'b1;
        t = 0;
        while (!press[0] && t < 30) begin step(1); t++; end
        check("postrst_press_delay", 32'(t), 12);
        step(15);
        check("postrst_press_once", 32'(press_cnt[0] - snap_p0), 1);
        check("rst_no_release_pulse", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] - snap_rel), 0);

        check("no_press_release_overlap", 32'(overlap_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
